fejkon_identity_reader: RTL and testbench



---
 rtl/fejkon_identity_pkg.sv | 14 +
 rtl/fejkon_identity_reader_if.sv | 10 +
 rtl/fejkon_identity_reader.sv | 117 +++++++++++
 tb/tb_fejkon_identity_reader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fejkon_identity_pkg.sv
// fejkon_identity_pkg: shared state/error encodings and the identity word-0 field layout.
package fejkon_identity_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ0, ST_WAIT0, ST_REQ1, ST_WAIT1, ST_CHECK, ST_DONE, ST_FAIL
  } state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_MAGIC, ERR_PORTS, ERR_TIMEOUT} err_e;
  localparam logic [23:0] IDENTITY_MAGIC = 24'h010DE5;
  localparam int MAGIC_LSB = 0;
  localparam int MAGIC_MSB = 23;
  localparam int FC_LSB = 24;
  localparam int FC_MSB = 27;
  localparam int ETH_LSB = 28;
  localparam int ETH_MSB = 31;
endpackage

// File: rtl/fejkon_identity_reader_if.sv
// fejkon_identity_reader_if: Avalon-MM read-only link between identity reader and identity slave.
interface fejkon_identity_reader_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  modport master (output address, read, input waitrequest, readdata, readdatavalid);
  modport slave (input address, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/fejkon_identity_reader.sv
// fejkon_identity_reader: scans the two identity words after reset or on rescan and checks them.
module fejkon_identity_reader
  import fejkon_identity_pkg::*;
#(
  parameter int unsigned TimeoutCycles  = 255,
  parameter logic [23:0] ExpectedMagic  = IDENTITY_MAGIC,
  parameter logic [3:0]  ExpectFcPorts  = 4'd0,
  parameter logic [3:0]  ExpectEthPorts = 4'd0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            rescan,
  fejkon_identity_reader_if.master        mm,
  output logic [3:0]                      fc_ports,
  output logic [3:0]                      eth_ports,
  output logic [31:0]                     git_hash,
  output logic                            id_valid,
  output logic                            id_error,
  output logic [1:0]                      err_code,
  output logic                            busy
);
  state_e      state_q, state_d;
  err_e        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] word0_q, word0_d, word1_q, word1_d, hash_q, hash_d;
  logic [3:0]  fc_q, fc_d, eth_q, eth_d;
  logic        read_q, read_d, addr_q, addr_d;
  logic        valid_q, valid_d, error_q, error_d, busy_q, busy_d;
  logic        timeout, magic_bad, ports_bad, in_bus;
  assign timeout   = cnt_q == 16'(TimeoutCycles);
  assign magic_bad = word0_q[MAGIC_MSB:MAGIC_LSB] != ExpectedMagic;
  assign ports_bad = (ExpectFcPorts != 4'd0 && word0_q[FC_MSB:FC_LSB] != ExpectFcPorts) ||
                     (ExpectEthPorts != 4'd0 && word0_q[ETH_MSB:ETH_LSB] != ExpectEthPorts);
  assign in_bus    = state_q inside {ST_REQ0, ST_WAIT0, ST_REQ1, ST_WAIT1};
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    word0_d = word0_q;
    word1_d = word1_q;
    fc_d    = fc_q;
    eth_d   = eth_q;
    hash_d  = hash_q;
    case (state_q)
      ST_IDLE:  state_d = ST_REQ0;
      ST_REQ0:  state_d = !mm.waitrequest ? ST_WAIT0 : timeout ? ST_FAIL : ST_REQ0;
      ST_WAIT0: begin
        state_d = mm.readdatavalid ? ST_REQ1 : timeout ? ST_FAIL : ST_WAIT0;
        word0_d = mm.readdatavalid ? mm.readdata : word0_q;
      end
      ST_REQ1:  state_d = !mm.waitrequest ? ST_WAIT1 : timeout ? ST_FAIL : ST_REQ1;
      ST_WAIT1: begin
        state_d = mm.readdatavalid ? ST_CHECK : timeout ? ST_FAIL : ST_WAIT1;
        word1_d = mm.readdatavalid ? mm.readdata : word1_q;
      end
      ST_CHECK: begin
        fc_d    = word0_q[FC_MSB:FC_LSB];
        eth_d   = word0_q[ETH_MSB:ETH_LSB];
        hash_d  = word1_q;
        err_d   = magic_bad ? ERR_MAGIC : ports_bad ? ERR_PORTS : ERR_NONE;
        state_d = (magic_bad || ports_bad) ? ST_FAIL : ST_DONE;
      end
      default: begin
        state_d = rescan ? ST_REQ0 : state_q;
        err_d   = rescan ? ERR_NONE : err_q;
      end
    endcase
    err_d   = (in_bus && state_d == ST_FAIL) ? ERR_TIMEOUT : err_d;
    // counter restarts each time a new read is issued, so every word gets the full budget
    cnt_d   = (state_d inside {ST_REQ0, ST_REQ1} && state_d != state_q) ? 16'd0 :
              in_bus ? cnt_q + 16'd1 : cnt_q;
    read_d  = state_d inside {ST_REQ0, ST_REQ1};
    addr_d  = state_d inside {ST_REQ1, ST_WAIT1};
    valid_d = state_d == ST_DONE;
    error_d = state_d == ST_FAIL;
    busy_d  = state_d inside {ST_REQ0, ST_WAIT0, ST_REQ1, ST_WAIT1, ST_CHECK};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      word0_q <= '0;
      word1_q <= '0;
      fc_q    <= '0;
      eth_q   <= '0;
      hash_q  <= '0;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
      fc_q    <= fc_d;
      eth_q   <= eth_d;
      hash_q  <= hash_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end
  assign mm.read    = read_q;
  assign mm.address = addr_q;
  assign fc_ports   = fc_q;
  assign eth_ports  = eth_q;
  assign git_hash   = hash_q;
  assign id_valid   = valid_q;
  assign id_error   = error_q;
  assign err_code   = err_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_fejkon_identity_reader.sv
// tb_fejkon_identity_reader: directed scans against a small Avalon slave model with stall/latency knobs.
module tb_fejkon_identity_reader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rescan = 1'b0;
  always #5 clk = ~clk;
  fejkon_identity_reader_if mm_a ();
  fejkon_identity_reader_if mm_b ();
  assign mm_b.waitrequest   = mm_a.waitrequest;
  assign mm_b.readdata      = mm_a.readdata;
  assign mm_b.readdatavalid = mm_a.readdatavalid;
  logic [3:0]  fc_a, eth_a, fc_b, eth_b;
  logic [31:0] hash_a, hash_b;
  logic        valid_a, error_a, busy_a, valid_b, error_b, busy_b;
  logic [1:0]  err_a, err_b;
  fejkon_identity_reader #(.TimeoutCycles(8)) u_a (
    .clk(clk), .reset_n(reset_n), .rescan(rescan), .mm(mm_a),
    .fc_ports(fc_a), .eth_ports(eth_a), .git_hash(hash_a),
    .id_valid(valid_a), .id_error(error_a), .err_code(err_a), .busy(busy_a));
  fejkon_identity_reader #(.TimeoutCycles(8), .ExpectFcPorts(4'd2)) u_b (
    .clk(clk), .reset_n(reset_n), .rescan(rescan), .mm(mm_b),
    .fc_ports(fc_b), .eth_ports(eth_b), .git_hash(hash_b),
    .id_valid(valid_b), .id_error(error_b), .err_code(err_b), .busy(busy_b));
  logic [31:0] words [2];
  int          stall_left = 0;
  int          latency = 1;
  int          pend = 0;
  logic        pend_addr = 1'b0;
  bit          resp_en = 1'b1;
  bit          inject = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  // slave model: outputs for the current cycle are set on the falling edge
  initial begin
    mm_a.waitrequest = 1'b0;
    mm_a.readdatavalid = 1'b0;
    mm_a.readdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mm_a.waitrequest = 1'b0;
        mm_a.readdatavalid = 1'b0;
        pend = 0;
      end else begin
        mm_a.readdatavalid = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0 && resp_en) begin
            mm_a.readdatavalid = 1'b1;
            mm_a.readdata = words[pend_addr];
          end
        end
        if (inject) begin
          inject = 1'b0;
          mm_a.readdatavalid = 1'b1;
          mm_a.readdata = 32'hFFFF_FFFF;
        end
        mm_a.waitrequest = 1'b0;
        if (mm_a.read) begin
          if (stall_left > 0) begin
            stall_left--;
            mm_a.waitrequest = 1'b1;
          end else begin
            pend = latency;
            pend_addr = mm_a.address;
          end
        end
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_rescan();
    rescan = 1'b1;
    @(negedge clk);
    rescan = 1'b0;
  endtask
  initial begin
    words[0] = 32'h2101_0DE5;
    words[1] = 32'hDEAD_BEEF;
    tick(3);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_read", mm_a.read, 0);
    check("rst_addr", mm_a.address, 0);
    check("rst_hash", hash_a, 0);
    check("rst_err", err_a, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("p1_t_read", mm_a.read, 1);
    check("p1_t_addr", mm_a.address, 0);
    tick(4);
    check("p1_t4_valid", valid_a, 0);
    check("p1_t4_busy", busy_a, 1);
    tick(1);
    check("p1_valid", valid_a, 1);
    check("p1_err", err_a, 0);
    check("p1_fc", fc_a, 1);
    check("p1_eth", eth_a, 2);
    check("p1_hash", hash_a, 32'hDEAD_BEEF);
    check("p1_busy", busy_a, 0);
    check("p1b_err", err_b, 2);
    check("p1b_valid", valid_b, 0);
    check("p1b_error", error_b, 1);
    words[0] = 32'h2201_0DE4;
    tick(1);
    pulse_rescan();
    check("p2_read", mm_a.read, 1);
    check("p2_valid_clr", valid_a, 0);
    tick(5);
    check("p2_error", error_a, 1);
    check("p2_err", err_a, 1);
    check("p2_valid", valid_a, 0);
    check("p2_fc", fc_a, 2);
    check("p2_eth", eth_a, 2);
    words[0] = 32'h2101_0DE5;
    words[1] = 32'h1234_5678;
    stall_left = 3;
    latency = 4;
    tick(1);
    pulse_rescan();
    check("p3_error_clr", error_a, 0);
    check("p3_err_clr", err_a, 0);
    for (int i = 0; i < 3; i++) begin
      check("p3_stall_read", mm_a.read, 1);
      check("p3_stall_addr", mm_a.address, 0);
      tick(1);
    end
    check("p3_accept_read", mm_a.read, 1);
    tick(10);
    check("p3_t13_valid", valid_a, 0);
    tick(1);
    check("p3_t14_valid", valid_a, 1);
    check("p3_hash", hash_a, 32'h1234_5678);
    latency = 1;
    resp_en = 1'b0;
    tick(1);
    pulse_rescan();
    tick(8);
    check("p4_t8_error", error_a, 0);
    check("p4_t8_busy", busy_a, 1);
    tick(1);
    check("p4_error", error_a, 1);
    check("p4_err", err_a, 3);
    check("p4_read", mm_a.read, 0);
    check("p4_busy", busy_a, 0);
    check("p4_hash_kept", hash_a, 32'h1234_5678);
    check("p4_fc_kept", fc_a, 1);
    tick(10);
    @(posedge clk);
    inject = 1'b1;
    @(negedge clk);
    tick(2);
    check("p4_late_error", error_a, 1);
    check("p4_late_err", err_a, 3);
    check("p4_late_read", mm_a.read, 0);
    check("p4_late_hash", hash_a, 32'h1234_5678);
    resp_en = 1'b1;
    pulse_rescan();
    tick(5);
    check("p4_rescan_valid", valid_a, 1);
    check("p4_rescan_err", err_a, 0);
    words[1] = 32'hCAFE_F00D;
    pulse_rescan();
    tick(1);
    pulse_rescan();
    check("p5_req1_read", mm_a.read, 1);
    check("p5_req1_addr", mm_a.address, 1);
    tick(3);
    check("p5_valid", valid_a, 1);
    check("p5_hash", hash_a, 32'hCAFE_F00D);
    tick(1);
    check("p5_no_latch_read", mm_a.read, 0);
    check("p5_no_latch_busy", busy_a, 0);
    check("p5_no_latch_valid", valid_a, 1);
    words[1] = 32'h0BAD_F00D;
    pulse_rescan();
    tick(3);
    check("p6_pre_busy", busy_a, 1);
    check("p6_pre_addr", mm_a.address, 1);
    #1 reset_n = 1'b0;
    #1;
    check("p6_rst_read", mm_a.read, 0);
    check("p6_rst_busy", busy_a, 0);
    check("p6_rst_valid", valid_a, 0);
    check("p6_rst_fc", fc_a, 0);
    check("p6_rst_eth", eth_a, 0);
    check("p6_rst_hash", hash_a, 0);
    check("p6_rst_addr", mm_a.address, 0);
    tick(2);
    reset_n = 1'b1;
    @(negedge clk);
    check("p6_restart_read", mm_a.read, 1);
    tick(5);
    check("p6_valid", valid_a, 1);
    check("p6_hash", hash_a, 32'h0BAD_F00D);
    check("p6_fc", fc_a, 1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
